// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider for the execute stage: stalls F/D/E until the quotient is ready.
// Optional macro DIV_SIGNED_EN builds the SDIV magnitude/sign-fixup path; otherwise SDIV behaves as UDIV.
module div_sequencer #(
  parameter int WIDTH            = 32,
  parameter int ALUCONTROL_WIDTH = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        StartE,
  input  logic [ALUCONTROL_WIDTH-1:0] ALUControlE,
  input  logic [WIDTH-1:0]            SrcAE,
  input  logic [WIDTH-1:0]            SrcBE,
  input  logic                        FlushE,
  output logic                        DivStallE,
  output logic                        DivBusyE,
  output logic                        DivDoneE,
  output logic [WIDTH-1:0]            DivResultE,
  output logic                        DivByZeroE
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [ALUCONTROL_WIDTH-1:0] OP_UDIV = ALUCONTROL_WIDTH'(14);
  localparam logic [ALUCONTROL_WIDTH-1:0] OP_SDIV = ALUCONTROL_WIDTH'(15);

  typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, dvs_q, dvs_d, res_q, res_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic             req;
  logic [WIDTH-1:0] a_mag, b_mag, fix_res;
  logic [WIDTH:0]   rem_sh, trial;

  assign req = StartE & ~FlushE & ((ALUControlE == OP_UDIV) | (ALUControlE == OP_SDIV));

`ifdef DIV_SIGNED_EN
  logic is_sdiv, neg_q, neg_d;
  assign is_sdiv = (ALUControlE == OP_SDIV);
  assign a_mag   = (is_sdiv & SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
  assign b_mag   = (is_sdiv & SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
  assign neg_d   = (state_q == IDLE && req) ? (is_sdiv & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1])) : neg_q;
  assign fix_res = neg_q ? -q_q : q_q;

  always_ff @(posedge clk or posedge reset)
    if (reset) neg_q <= 1'b0;
    else       neg_q <= neg_d;
`else
  assign a_mag   = SrcAE;
  assign b_mag   = SrcBE;
  assign fix_res = q_q;
`endif

  // Remainder is one bit wider so the trial subtraction's sign shows up in the MSB.
  assign rem_sh = {rem_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    dbz_d     = dbz_q;
    DivStallE = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        DivStallE = 1'b1;
        if (SrcBE == '0) begin
          res_d   = '0;
          dbz_d   = 1'b1;
          state_d = DONE;
        end else begin
          q_d     = a_mag;
          dvs_d   = b_mag;
          rem_d   = '0;
          cnt_d   = CW'(WIDTH-1);
          dbz_d   = 1'b0;
          state_d = ITER;
        end
      end
      ITER: begin
        DivStallE = 1'b1;
        rem_d     = trial[WIDTH] ? rem_sh : trial;
        q_d       = {q_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIXUP;
      end
      FIXUP: begin
        DivStallE = 1'b1;
        res_d     = fix_res;
        state_d   = DONE;
      end
      // The instruction that started us is still in E, so StartE is ignored here.
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (FlushE) begin
      state_d   = IDLE;
      DivStallE = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
    end
  end

  assign DivBusyE   = (state_q == ITER) | (state_q == FIXUP);
  assign DivDoneE   = (state_q == DONE);
  assign DivResultE = res_q;
  assign DivByZeroE = dbz_q;
endmodule
